// File: rtl/mux_rr_nx1_if.sv
// Streaming bundle for mux_rr_nx1: N producer channels in, one beat out.
// master = producers/consumer side, slave = the mux itself.
interface mux_rr_nx1_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_ch,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_ch,
    output out_valid
  );
endinterface

// File: rtl/mux_rr_nx1.sv
// N-to-1 streaming mux, registered output, round-robin or forced select.
// Ports: clk, rst_n, mode (0=rr,1=forced), sel, bus (slave handshake bundle).
module mux_rr_nx1 #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  mux_rr_nx1_if.slave   bus
);

  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    ch_q;
  logic             valid_q;
  logic [SW-1:0]    ptr;

  logic             load_en;
  logic             gnt;
  logic [SW-1:0]    gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SW:0]      scan;
  logic [SW-1:0]    ptr_nxt;

  assign load_en = !valid_q || bus.out_ready;

  // Grant search. The rr scan index is one bit wider so that
  // ptr+i cannot overflow before the modulo-N fold.
  always_comb begin
    gnt     = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    unique case (1'b1)
      mode: begin
        // Only indices below N exist, so sel >= N never grants.
        for (int k = 0; k < N; k++) begin
          if (sel == SW'(k) && bus.in_valid[k]) begin
            gnt     = 1'b1;
            gnt_idx = sel;
          end
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          scan = {1'b0, ptr} + (SW+1)'(i);
          if (scan >= (SW+1)'(N))
            scan = scan - (SW+1)'(N);
          if (!gnt && bus.in_valid[scan]) begin
            gnt     = 1'b1;
            gnt_idx = scan[SW-1:0];
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SW'(k)) begin
        gnt_data        = bus.in_data[k*WIDTH +: WIDTH];
        bus.in_ready[k] = load_en && gnt;
      end
    end
  end

  assign ptr_nxt = (gnt_idx == SW'(N-1)) ? '0
                 : gnt_idx + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (load_en && gnt) begin
      data_q  <= gnt_data;
      ch_q    <= gnt_idx;
      valid_q <= 1'b1;
      if (!mode)
        ptr <= ptr_nxt;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Scoreboard bench for mux_rr_nx1 (WIDTH=4, N=4).
// Stimulus pushes expected beats; a negedge monitor pops on transfer.
module tb_mux_rr_nx1;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] ch;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic [SW-1:0] sel = '0;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  mux_rr_nx1_if #(.WIDTH(W), .N(N), .SW(SW)) bus ();

  mux_rr_nx1 #(.WIDTH(W), .N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d,
                      input logic [SW-1:0] ch);
    exp_t e;
    e.d  = d;
    e.ch = ch;
    q.push_back(e);
  endtask

  task automatic set_data(input logic [W-1:0] d0,
                          input logic [W-1:0] d1,
                          input logic [W-1:0] d2,
                          input logic [W-1:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    mode          = 1'b0;
    sel           = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: a beat transfers on the next edge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 32'(bus.out_data), 32'hFFFF);
        end else begin
          e = q.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(e.d));
          chk("sb_ch", 32'(bus.out_ch), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    int budget;
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_ch", 32'(bus.out_ch), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    do_reset();

    // Round-robin fairness over four valid channels.
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    push(4'd1, 2'd0); push(4'd2, 2'd1);
    push(4'd3, 2'd2); push(4'd4, 2'd3);
    push(4'd1, 2'd0); push(4'd2, 2'd1);
    repeat (6) step();
    bus.in_valid = '0;
    step();

    // Mid-stream async reset discards a held beat.
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    step();
    chk("hold_valid", 32'(bus.out_valid), 1);
    chk("hold_ch", 32'(bus.out_ch), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_data", 32'(bus.out_data), 0);
    chk("arst_ch", 32'(bus.out_ch), 0);
    bus.out_ready = 1'b1;
    push(4'd1, 2'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_ch", 32'(bus.out_ch), 0);
    bus.in_valid = '0;
    step();

    // Skip and wrap: ptr=3 after granting ch2.
    do_reset();
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0100;
    push(4'd3, 2'd2);
    step();
    bus.in_valid = 4'b0101;
    push(4'd1, 2'd0); push(4'd3, 2'd2);
    push(4'd1, 2'd0);
    repeat (3) step();
    bus.in_valid = '0;
    step();

    // Forced channel.
    do_reset();
    set_data(4'd1, 4'd2, 4'hA, 4'd4);
    mode          = 1'b1;
    sel           = 2'd2;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(4'hA, 2'd2);
      #1 chk("forced_ready", 32'(bus.in_ready), 32'b0100);
      step();
    end
    bus.in_valid = 4'b1011;
    #1 chk("forced_drop_ready", 32'(bus.in_ready), 0);
    step();
    chk("forced_drop_valid", 32'(bus.out_valid), 0);

    // Backpressure holds beat, in_ready and ptr.
    do_reset();
    set_data(4'd5, 4'd6, 4'd7, 4'd8);
    bus.in_valid = 4'b0001;
    push(4'd5, 2'd0);
    step();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", 32'(bus.out_data), 5);
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_ready", 32'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    push(4'd6, 2'd1);
    step();
    chk("bp_swap_data", 32'(bus.out_data), 6);
    chk("bp_swap_valid", 32'(bus.out_valid), 1);
    bus.in_valid = '0;
    step();

    // Mode switch: forced beats leave ptr at 1.
    do_reset();
    set_data(4'd1, 4'd2, 4'd3, 4'd4);
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0001;
    push(4'd1, 2'd0);
    step();
    mode = 1'b1;
    sel  = 2'd3;
    bus.in_valid = 4'b1111;
    push(4'd4, 2'd3); push(4'd4, 2'd3);
    repeat (2) step();
    mode = 1'b0;
    push(4'd2, 2'd1); push(4'd3, 2'd2);
    repeat (2) step();
    bus.in_valid = '0;
    step();

    budget = 20;
    while (q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("sb_drain", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
